// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  localparam inst_t      ZERO_WORD  = '0;
  localparam inst_addr_t INITIAL_PC = '0;
  localparam inst_addr_t PC_STEP    = 32'd4;
  localparam logic       RST_ENABLE = 1'b0;

  typedef enum logic {
    IF_RUN   = 1'b0,
    IF_REDIR = 1'b1
  } if_state_e;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction ROM read port: single-outstanding request/ack with same-cycle data.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic       rom_req_o;
  inst_addr_t rom_addr_o;
  logic       rom_ack_i;
  inst_t      rom_data_i;

  modport master (output rom_req_o, output rom_addr_o, input rom_ack_i, input rom_data_i);
  modport slave  (input rom_req_o, input rom_addr_o, output rom_ack_i, output rom_data_i);

endinterface

// File: rtl/if_prefetch_fifo.sv
// Prefetch queue of {pc, inst} entries; flush takes priority over push.
module if_prefetch_fifo
  import if_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output fetch_entry_t           head_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fetch_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_rd_ptr;
  logic [AW-1:0]  r_wr_ptr;
  logic [AW:0]    r_count;
  logic           w_push;
  logic           w_pop;

  assign w_pop  = pop_i && (r_count != '0);
  assign w_push = push_i && ((r_count != FULL_CNT) || w_pop);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush_i) r_mem[r_wr_ptr] <= push_data_i;
  end

  assign head_o  = r_mem[r_rd_ptr];
  assign empty_o = (r_count == '0);
  assign count_o = r_count;

endmodule

// File: rtl/if_fetch.sv
// Fetch stage: PC ownership, single-outstanding ROM reads, prefetch queue and
// IF/ID register, with delay-slot-aware branch redirect.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter inst_addr_t  RESET_PC = INITIAL_PC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_i,
  input  logic          branch_flag_i,
  input  inst_addr_t    branch_target_address_i,
  if_fetch_if.master    rom,
  output inst_addr_t    pc_o,
  output inst_t         inst_o,
  output logic          valid_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  if_state_e    r_state, w_state_nxt;
  inst_addr_t   r_fetch_pc, w_fetch_pc_nxt;
  inst_addr_t   r_target, w_target_nxt;
  logic         r_req, w_req_nxt;
  logic         r_drop, w_drop_nxt;
  inst_addr_t   r_pc;
  inst_t        r_inst;
  logic         r_valid;

  fetch_entry_t w_head;
  logic         w_empty;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_cnt_after;
  logic         w_ack, w_ack_keep, w_inflight, w_take;
  logic         w_bypass, w_push, w_pop, w_flush;
  inst_addr_t   w_ds_pc;

  assign w_ack      = r_req && rom.rom_ack_i;
  assign w_ack_keep = w_ack && !r_drop;
  assign w_inflight = r_req && !w_ack;
  assign w_take     = (r_state == IF_RUN) && branch_flag_i && !stall_i && r_valid;
  assign w_ds_pc    = r_pc + PC_STEP;

  // Empty queue + arriving word + free output: skip the queue for one-cycle latency.
  assign w_bypass = !stall_i && w_empty && w_ack_keep;
  assign w_pop    = !stall_i && !w_empty;
  assign w_push   = w_ack_keep && !w_bypass;

  if_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (w_push),
    .push_data_i ({rom.rom_addr_o, rom.rom_data_i}),
    .pop_i       (w_pop),
    .flush_i     (w_flush),
    .head_o      (w_head),
    .empty_o     (w_empty),
    .count_o     (w_count)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = w_ack ? (r_fetch_pc + PC_STEP) : r_fetch_pc;
    w_target_nxt   = r_target;
    w_drop_nxt     = r_drop && !w_ack;
    w_flush        = 1'b0;
    case (r_state)
      IF_RUN: begin
        if (w_take) begin
          if (!w_empty && (w_head.pc == w_ds_pc)) begin
            // Delay slot is at the head: it pops to the output while the rest flushes.
            w_flush = 1'b1;
            if (w_inflight) begin
              w_drop_nxt   = 1'b1;
              w_target_nxt = branch_target_address_i;
              w_state_nxt  = IF_REDIR;
            end else begin
              w_fetch_pc_nxt = branch_target_address_i;
            end
          end else if (w_empty && r_req && (r_fetch_pc == w_ds_pc)) begin
            if (w_ack) begin
              w_fetch_pc_nxt = branch_target_address_i;
            end else begin
              w_target_nxt = branch_target_address_i;
              w_state_nxt  = IF_REDIR;
            end
          end else if (w_empty && !r_req) begin
            w_fetch_pc_nxt = w_ds_pc;
            w_target_nxt   = branch_target_address_i;
            w_state_nxt    = IF_REDIR;
          end
        end
      end
      IF_REDIR: begin
        if (w_ack) begin
          w_fetch_pc_nxt = r_target;
          w_state_nxt    = IF_RUN;
        end
      end
      default: w_state_nxt = IF_RUN;
    endcase
  end

  always_comb begin
    if (w_flush) w_cnt_after = '0;
    else         w_cnt_after = w_count + CW'(w_push) - CW'(w_pop);
    w_req_nxt = w_inflight || (w_cnt_after < CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_state    <= IF_RUN;
      r_fetch_pc <= RESET_PC;
      r_target   <= '0;
      r_req      <= 1'b0;
      r_drop     <= 1'b0;
      r_pc       <= '0;
      r_inst     <= ZERO_WORD;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_target   <= w_target_nxt;
      r_req      <= w_req_nxt;
      r_drop     <= w_drop_nxt;
      if (!stall_i) begin
        if (w_bypass) begin
          r_pc    <= rom.rom_addr_o;
          r_inst  <= rom.rom_data_i;
          r_valid <= 1'b1;
        end else if (!w_empty) begin
          r_pc    <= w_head.pc;
          r_inst  <= w_head.inst;
          r_valid <= 1'b1;
        end else begin
          r_inst  <= ZERO_WORD;
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign rom.rom_req_o  = r_req;
  assign rom.rom_addr_o = r_fetch_pc;
  assign pc_o           = r_pc;
  assign inst_o         = r_inst;
  assign valid_o        = r_valid;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed reset/latency/backpressure/branch/wrap cases,
// then random ROM latency, stalls and branches against an instruction-stream model.
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       stall_i = 1'b0;
  logic       branch_flag_i = 1'b0;
  inst_addr_t branch_target_address_i = '0;
  inst_addr_t pc_o, wr_pc;
  inst_t      inst_o, wr_inst;
  logic       valid_o, wr_valid;

  if_fetch_if rom_bus ();
  if_fetch_if wrap_bus ();

  if_fetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall_i                 (stall_i),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .rom                     (rom_bus),
    .pc_o                    (pc_o),
    .inst_o                  (inst_o),
    .valid_o                 (valid_o)
  );

  if_fetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk                     (clk),
    .rst                     (rst),
    .stall_i                 (1'b0),
    .branch_flag_i           (1'b0),
    .branch_target_address_i (32'h0),
    .rom                     (wrap_bus),
    .pc_o                    (wr_pc),
    .inst_o                  (wr_inst),
    .valid_o                 (wr_valid)
  );

  assign wrap_bus.rom_ack_i  = wrap_bus.rom_req_o;
  assign wrap_bus.rom_data_i = ~wrap_bus.rom_addr_o;

  inst_addr_t  wrap_addr [3];
  int unsigned n_wrap = 0;
  always @(negedge clk) begin
    if (rst && wrap_bus.rom_req_o && n_wrap < 3) begin
      wrap_addr[n_wrap] <= wrap_bus.rom_addr_o;
      n_wrap <= n_wrap + 1;
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic inst_t rom_word(input inst_addr_t a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Instruction-stream model: program order with one delay slot after each taken branch.
  inst_addr_t  exp_pc = '0;
  logic        exp_ds = 1'b0;
  logic        cur_ds = 1'b0;
  inst_addr_t  tgt = '0;
  logic        new_pres = 1'b0;
  int unsigned n_pres = 0;
  int unsigned n_br = 0;

  logic        rom_pend = 1'b0;
  int unsigned rom_cnt = 0;

  task automatic rom_drive(input int unsigned lat_max);
    logic ack;
    ack = 1'b0;
    if (rom_bus.rom_req_o === 1'b1) begin
      if (!rom_pend) begin
        rom_pend = 1'b1;
        rom_cnt  = $urandom_range(lat_max, 0);
      end
      if (rom_cnt == 0) ack = 1'b1;
      else rom_cnt--;
    end
    rom_bus.rom_ack_i  = ack;
    rom_bus.rom_data_i = ack ? rom_word(rom_bus.rom_addr_o) : 32'hDEAD_BEEF;
  endtask

  task automatic drive(input int unsigned lat_max, input int unsigned p_stall, input int unsigned p_br);
    stall_i = ($urandom_range(99, 0) < p_stall);
    branch_flag_i = 1'b0;
    branch_target_address_i = $urandom_range(32'h0000_FFFF, 0) << 2;
    if ($urandom_range(99, 0) < p_br) begin
      if (stall_i || !valid_o) begin
        branch_flag_i = 1'b1;
      end else if (!cur_ds) begin
        branch_flag_i = 1'b1;
        tgt    = branch_target_address_i;
        exp_ds = 1'b1;
        n_br++;
      end
    end
    rom_drive(lat_max);
  endtask

  task automatic step();
    logic p_stall, p_rst, p_req, p_ack;
    inst_addr_t p_addr;
    p_stall = stall_i;
    p_rst   = rst;
    p_req   = rom_bus.rom_req_o;
    p_ack   = rom_bus.rom_ack_i;
    p_addr  = rom_bus.rom_addr_o;
    @(posedge clk);
    #1;
    new_pres = 1'b0;
    if (p_ack || !p_rst) rom_pend = 1'b0;
    if (!p_rst) begin
      exp_pc = 32'h0;
      exp_ds = 1'b0;
      cur_ds = 1'b0;
    end else begin
      if (p_req === 1'b1 && p_ack !== 1'b1) begin
        chk("req_hold", rom_bus.rom_req_o, 1);
        chk("addr_hold", rom_bus.rom_addr_o, p_addr);
      end
      if (!p_stall && valid_o) begin
        chk("stream_pc", pc_o, exp_pc);
        chk("stream_inst", inst_o, rom_word(exp_pc));
        cur_ds = exp_ds;
        exp_pc = exp_ds ? tgt : exp_pc + 32'd4;
        exp_ds = 1'b0;
        new_pres = 1'b1;
        n_pres++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    stall_i = 1'b0;
    branch_flag_i = 1'b0;
    rom_bus.rom_ack_i  = 1'b1;
    rom_bus.rom_data_i = 32'hBAD0_BAD0;
    repeat (2) step();
    rst = 1'b1;
    rom_bus.rom_ack_i = 1'b0;
  endtask

  task automatic wait_pres(output inst_addr_t pc, input int unsigned lat_max);
    logic got;
    got = 1'b0;
    pc  = '1;
    for (int i = 0; i < 40 && !got; i++) begin
      drive(lat_max, 0, 0);
      step();
      if (new_pres) begin
        got = 1'b1;
        pc  = pc_o;
      end
    end
    chk("pres_seen", got, 1);
  endtask

  initial begin
    logic       seen_req, a_ack;
    inst_addr_t a_addr, p;
    int unsigned n_ack;

    do_reset();
    chk("rst_req", rom_bus.rom_req_o, 0);
    chk("rst_addr", rom_bus.rom_addr_o, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_valid", valid_o, 0);

    seen_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0);
      a_ack  = rom_bus.rom_ack_i;
      a_addr = rom_bus.rom_addr_o;
      if (!seen_req && rom_bus.rom_req_o) begin
        seen_req = 1'b1;
        chk("first_addr", a_addr, 32'h0);
      end
      step();
      if (a_ack) begin
        chk("lat_valid", valid_o, 1);
        chk("lat_pc", pc_o, a_addr);
      end
    end
    chk("first_req_seen", seen_req, 1);

    do_reset();
    for (int i = 0; i < 10 && !valid_o; i++) begin
      drive(0, 0, 0);
      step();
    end
    chk("bp_start_valid", valid_o, 1);
    chk("bp_start_pc", pc_o, 32'h0);
    n_ack = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 100, 0);
      if (rom_bus.rom_ack_i) n_ack++;
      step();
      chk("bp_pc_hold", pc_o, 32'h0);
    end
    chk("bp_acks", n_ack, 4);
    chk("bp_req_off", rom_bus.rom_req_o, 0);
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 0);
      step();
      chk("bp_rel_valid", valid_o, 1);
      chk("bp_rel_pc", pc_o, 32'(4 * k));
    end

    drive(0, 0, 0);
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h100;
    tgt    = 32'h100;
    exp_ds = 1'b1;
    step();
    chk("br_ds_new", new_pres, 1);
    chk("br_ds_pc", pc_o, 32'h14);
    wait_pres(p, 0);
    chk("br_tgt_pc", p, 32'h100);

    for (int i = 0; i < 4000; i++) begin
      drive(5, 30, 25);
      step();
    end
    chk("progress", n_pres >= 300, 1);
    chk("branches", n_br >= 20, 1);

    chk("wrap_n", n_wrap, 3);
    chk("wrap0", wrap_addr[0], 32'hFFFF_FFF8);
    chk("wrap1", wrap_addr[1], 32'hFFFF_FFFC);
    chk("wrap2", wrap_addr[2], 32'h0000_0000);
    chk("wrap_valid", wr_valid, 1);
    chk("wrap_inst", wr_inst, ~wr_pc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
